// File: rtl/sp_ram_stream_reader_if.sv
// sp_ram_stream_reader_if
//  Groups the sp_ram word-port request/response signals and the outgoing valid/ready
//  stream used by sp_ram_stream_reader.
//  master modport: the reader (drives RAM requests and stream beats).
//  slave modport : the RAM plus stream sink (returns read data, drives m_ready).
//  Signals:
//   mem_en / mem_addr / mem_we / mem_be / mem_wdata  request to the RAM
//   mem_rdata                                       read data, one cycle after mem_en
//   m_valid / m_data / m_last                       stream beat towards the sink
//   m_ready                                         sink accept
interface sp_ram_stream_reader_if #(
   parameter int unsigned ADDR_WIDTH = 15,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                      mem_en;
   logic [ADDR_WIDTH-1:0]     mem_addr;
   logic                      mem_we;
   logic [DATA_WIDTH/8-1:0]   mem_be;
   logic [DATA_WIDTH-1:0]     mem_wdata;
   logic [DATA_WIDTH-1:0]     mem_rdata;
   logic                      m_valid;
   logic [DATA_WIDTH-1:0]     m_data;
   logic                      m_last;
   logic                      m_ready;

   modport master (
      output mem_en,
      output mem_addr,
      output mem_we,
      output mem_be,
      output mem_wdata,
      input  mem_rdata,
      output m_valid,
      output m_data,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  mem_en,
      input  mem_addr,
      input  mem_we,
      input  mem_be,
      input  mem_wdata,
      output mem_rdata,
      input  m_valid,
      input  m_data,
      input  m_last,
      output m_ready
   );
endinterface

// File: rtl/sp_ram_stream_reader.sv
// sp_ram_stream_reader
//  Read initiator for the banked sp_ram word port. On a start command it fetches len_i
//  consecutive words from a word-aligned byte base address and emits them in ascending
//  address order as a valid/ready stream. The RAM's one-cycle read latency is absorbed by a
//  2-entry buffer; requests are only issued when the buffer is guaranteed to have room for
//  the returning word, so backpressure never drops data. Addresses wrap modulo 2^ADDR_WIDTH.
//  Ports:
//   clk          clock
//   rst_i        synchronous active-high reset (aborts a running command, no done_o)
//   start_i      command strobe, accepted only while busy_o = 0
//   base_addr_i  byte base address, low byte-offset bits ignored
//   len_i        number of words to read, 0 completes immediately
//   busy_o       command in progress
//   done_o       one-cycle pulse when a command completes
//   bus          RAM request/response and output stream (master side)
module sp_ram_stream_reader #(
   parameter int unsigned ADDR_WIDTH = 15,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 14
) (
   input  logic                  clk,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
   output logic                  busy_o,
   output logic                  done_o,
   sp_ram_stream_reader_if.master bus
);

   localparam logic [ADDR_WIDTH-1:0] AddrStep = ADDR_WIDTH'(DATA_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] AddrMask = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);
   localparam logic [LEN_WIDTH-1:0]  LenOne   = LEN_WIDTH'(1);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  issue_left_q, issue_left_d;
   logic [LEN_WIDTH-1:0]  beats_left_q, beats_left_d;
   logic                  done_q, done_d;
   logic                  inflight_q;

   // 2-entry buffer
   logic [DATA_WIDTH-1:0] fifo_q [2];
   logic                  rd_ptr_q, wr_ptr_q;
   logic [1:0]            count_q, count_d;

   logic                  mem_en;
   logic                  m_valid;
   logic                  pop;
   logic                  push;
   logic [2:0]            occupancy;
   logic                  credit_ok;

   // Stream side and buffer bookkeeping
   always_comb begin
      m_valid   = (count_q != 2'd0);
      pop       = m_valid & bus.m_ready;
      push      = inflight_q;
      // Words that will sit in the buffer next cycle if nothing new is issued now.
      // pop implies count_q >= 1, so this never underflows.
      occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
      credit_ok = (occupancy < 3'd2);
      count_d   = count_q + {1'b0, push} - {1'b0, pop};
   end

   // Command FSM
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      issue_left_d = issue_left_q;
      beats_left_d = beats_left_q;
      done_d       = 1'b0;
      mem_en       = 1'b0;

      if (pop) begin
         beats_left_d = beats_left_q - LenOne;
      end

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               addr_d       = base_addr_i & ~AddrMask;
               issue_left_d = len_i;
               beats_left_d = len_i;
               if (len_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            mem_en = credit_ok;
            if (credit_ok) begin
               addr_d       = addr_q + AddrStep;
               issue_left_d = issue_left_q - LenOne;
               if (issue_left_q == LenOne) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (pop && (beats_left_q == LenOne)) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         issue_left_q <= '0;
         beats_left_q <= '0;
         done_q       <= 1'b0;
         inflight_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         issue_left_q <= issue_left_d;
         beats_left_q <= beats_left_d;
         done_q       <= done_d;
         inflight_q   <= mem_en;
      end
   end

   // Push is unconditional on a returning read: the credit check at issue time already
   // reserved the slot. When full with a simultaneous pop, wr_ptr equals rd_ptr and the
   // head is overwritten only after it has been consumed this cycle.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= bus.mem_rdata;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

   assign busy_o        = (state_q != StIdle);
   assign done_o        = done_q;

   assign bus.mem_en    = mem_en;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_we    = 1'b0;
   assign bus.mem_be    = '1;
   assign bus.mem_wdata = '0;

   assign bus.m_valid   = m_valid;
   assign bus.m_data    = fifo_q[rd_ptr_q];
   assign bus.m_last    = m_valid & (beats_left_q == LenOne);

endmodule

// File: tb/tb_sp_ram_stream_reader.sv
module tb_sp_ram_stream_reader;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [14:0] base_addr_i;
   logic [13:0] len_i;
   logic        busy_o;
   logic        done_o;

   int errors = 0;
   int checks = 0;

   sp_ram_stream_reader_if #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) bus ();

   sp_ram_stream_reader #(
      .ADDR_WIDTH(15),
      .DATA_WIDTH(32),
      .LEN_WIDTH (14)
   ) dut (
      .clk        (clk),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .base_addr_i(base_addr_i),
      .len_i      (len_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input logic [14:0] a);
      return {17'h1C0DE, a};
   endfunction

   // RAM model: one-cycle read latency; garbage when not enabled so stray pushes show up
   always @(posedge clk) begin
      if (bus.mem_en) bus.mem_rdata <= pat(bus.mem_addr);
      else            bus.mem_rdata <= 32'hDEAD_BEEF;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [14:0] base;
      logic [13:0] len;
      logic        toggle;     // m_ready alternates 1/0 per cycle
      logic [14:0] first_addr;
      logic [14:0] last_addr;
      int          done_lat;   // cycles from start to done_o; 0 = not checked
   } vec_t;

   task automatic run_vec(input vec_t v);
      int          beat = 0;
      int          issues = 0;
      int          first_issue = -1;
      int          first_valid = -1;
      int          done_cyc = -1;
      int          occ = 0;
      int          infl = 0;
      int          popi;
      logic        prev_stall = 1'b0;
      logic [31:0] prev_data = '0;
      logic        prev_last = 1'b0;
      logic [14:0] last_issue_addr = '0;
      logic [14:0] exp_a;

      @(negedge clk);
      start_i     = 1'b1;
      base_addr_i = v.base;
      len_i       = v.len;
      bus.m_ready = 1'b0;
      for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
         @(negedge clk);
         start_i     = 1'b0;
         bus.m_ready = v.toggle ? c[0] : 1'b1;
         #1;
         popi = (bus.m_valid && bus.m_ready) ? 1 : 0;
         check("valid_vs_model", 32'(bus.m_valid), 32'(occ > 0));
         if (c == 1 && v.len != 0) check("busy_cycle1", 32'(busy_o), 32'd1);
         if (bus.mem_en) begin
            check("credit", 32'((occ + infl - popi) < 2), 32'd1);
            exp_a = v.first_addr + 15'(4 * issues);
            check("issue_addr", 32'(bus.mem_addr), 32'(exp_a));
            if (issues == 0) first_issue = c;
            last_issue_addr = bus.mem_addr;
            issues++;
         end
         if (prev_stall) begin
            check("stall_data", bus.m_data, prev_data);
            check("stall_last", 32'(bus.m_last), 32'(prev_last));
         end
         if (bus.m_valid && first_valid < 0) first_valid = c;
         if (popi != 0) begin
            exp_a = v.first_addr + 15'(4 * beat);
            check("beat_data", bus.m_data, pat(exp_a));
            check("beat_last", 32'(bus.m_last), 32'(beat == int'(v.len) - 1));
            beat++;
         end
         if (done_o) begin
            done_cyc = c;
            check("busy_at_done", 32'(busy_o), 32'd0);
         end
         prev_stall = bus.m_valid && !bus.m_ready;
         prev_data  = bus.m_data;
         prev_last  = bus.m_last;
         occ  = occ + infl - popi;
         infl = bus.mem_en ? 1 : 0;
      end
      if (done_cyc < 0) begin
         check("done_timeout", 32'd0, 32'd1);
      end else begin
         check("beat_count", 32'(beat), 32'(v.len));
         check("issue_count", 32'(issues), 32'(v.len));
         if (v.len != 0) begin
            check("first_issue_cycle", 32'(first_issue), 32'd1);
            check("first_valid_cycle", 32'(first_valid), 32'd3);
            check("last_issue_addr", 32'(last_issue_addr), 32'(v.last_addr));
         end
         if (v.done_lat != 0) check("done_latency", 32'(done_cyc), 32'(v.done_lat));
         @(negedge clk);
         #1;
         check("done_pulse_width", 32'(done_o), 32'd0);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},   32'(busy_o),       32'd0);
      check({tag, "_done"},   32'(done_o),       32'd0);
      check({tag, "_mem_en"}, 32'(bus.mem_en),   32'd0);
      check({tag, "_valid"},  32'(bus.m_valid),  32'd0);
      check({tag, "_last"},   32'(bus.m_last),   32'd0);
      check({tag, "_addr"},   32'(bus.mem_addr), 32'd0);
      check({tag, "_data"},   bus.m_data,        32'd0);
   endtask

   vec_t vecs [6];

   initial begin
      vecs[0] = '{15'h0000, 14'd4, 1'b0, 15'h0000, 15'h000C, 7};
      vecs[1] = '{15'h1FF8, 14'd4, 1'b0, 15'h1FF8, 15'h2004, 7};
      vecs[2] = '{15'h0200, 14'd8, 1'b1, 15'h0200, 15'h021C, 0};
      vecs[3] = '{15'h0010, 14'd0, 1'b0, 15'h0000, 15'h0000, 1};
      vecs[4] = '{15'h7FF8, 14'd3, 1'b0, 15'h7FF8, 15'h0000, 6};
      vecs[5] = '{15'h0003, 14'd2, 1'b0, 15'h0000, 15'h0004, 5};

      rst_i       = 1'b1;
      start_i     = 1'b0;
      base_addr_i = '0;
      len_i       = '0;
      bus.m_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      check("tie_we",    32'(bus.mem_we),   32'd0);
      check("tie_be",    32'(bus.mem_be),   32'hF);
      check("tie_wdata", bus.mem_wdata,     32'd0);
      rst_i = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Reset in DRAIN with both buffer entries occupied
      @(negedge clk);
      start_i     = 1'b1;
      base_addr_i = 15'h0100;
      len_i       = 14'd2;
      bus.m_ready = 1'b0;
      @(negedge clk);
      start_i = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("pre_rst_valid", 32'(bus.m_valid), 32'd1);
      check("pre_rst_busy",  32'(busy_o),      32'd1);
      check("pre_rst_data",  bus.m_data,       pat(15'h0100));
      rst_i = 1'b1;
      @(negedge clk);
      #1;
      check_idle_outputs("mid_rst");
      rst_i       = 1'b0;
      bus.m_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         check("post_rst_no_done",  32'(done_o),      32'd0);
         check("post_rst_no_valid", 32'(bus.m_valid), 32'd0);
      end
      run_vec('{15'h0040, 14'd4, 1'b0, 15'h0040, 15'h004C, 7});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
